// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state encoding and helpers for the fetch stage
package fetch_stage_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP        = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2
    } fetch_state_t;

    // Branch targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_instruction_memory.sv
// rtl/fetch_stage_instruction_memory.sv - instruction store with synchronous write port and asynchronous read
module instruction_memory
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [ADDR_W-1:0]  i_wr_addr,
    input  logic [INSTR_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]  i_rd_addr,
    output logic [INSTR_W-1:0] o_rd_data
);

    // Sized to a full power of two so truncated indices always alias cleanly.
    logic [INSTR_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, instruction fetch and IF/ID pipeline register with halt sequencing
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_pc_write,
    input  logic               i_if_id_write,
    input  logic               i_flush,
    input  logic               i_jump,
    input  logic [31:0]        i_jump_addr,
    input  logic               i_imem_wr_en,
    input  logic [31:0]        i_imem_wr_addr,
    input  logic [INSTR_W-1:0] i_imem_wr_data,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_if_id_pc4,
    output logic [INSTR_W-1:0] o_if_id_instr,
    output logic               o_halt
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [31:0]        r_pc;
    logic [31:0]        r_if_id_pc4;
    logic [INSTR_W-1:0] r_if_id_instr;
    logic               r_halt;
    fetch_state_t       r_state;

    logic [31:0]        w_pc_plus4;
    logic [INSTR_W-1:0] w_fetch_instr;
    logic [31-AW:0]     w_unused_wr_addr;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_unused_wr_addr = {i_imem_wr_addr[31:AW+2], i_imem_wr_addr[1:0]};

    instruction_memory #(
        .ADDR_W (AW)
    ) u_imem (
        .i_clk     (i_clk),
        .i_wr_en   (i_imem_wr_en),
        .i_wr_addr (i_imem_wr_addr[AW+1:2]),
        .i_wr_data (i_imem_wr_data),
        .i_rd_addr (r_pc[AW+1:2]),
        .o_rd_data (w_fetch_instr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= PC_RESET;
            r_if_id_pc4   <= '0;
            r_if_id_instr <= NOP;
            r_halt        <= 1'b0;
            r_state       <= ST_RUN;
        end else if (i_enable) begin
            case (r_state)
                ST_RUN: begin
                    if (i_pc_write) begin
                        r_pc <= i_jump ? word_align(i_jump_addr) : w_pc_plus4;
                    end
                    if (i_if_id_write) begin
                        if (i_flush) begin
                            r_if_id_pc4   <= '0;
                            r_if_id_instr <= NOP;
                        end else begin
                            r_if_id_pc4   <= w_pc_plus4;
                            r_if_id_instr <= w_fetch_instr;
                            // A flushed HALT never reaches IF/ID, so only this path can halt.
                            if (w_fetch_instr == HALT_INSTR) begin
                                r_state <= ST_HALTING;
                                r_halt  <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALTING: begin
                    if (i_if_id_write) begin
                        r_if_id_pc4   <= '0;
                        r_if_id_instr <= NOP;
                        r_state       <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    r_if_id_pc4   <= '0;
                    r_if_id_instr <= NOP;
                end
                default: begin
                    r_if_id_pc4   <= '0;
                    r_if_id_instr <= NOP;
                    r_halt        <= 1'b0;
                    r_state       <= ST_RUN;
                end
            endcase
        end
    end

    assign o_pc          = r_pc;
    assign o_if_id_pc4   = r_if_id_pc4;
    assign o_if_id_instr = r_if_id_instr;
    assign o_halt        = r_halt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_pc_write;
    logic        i_if_id_write;
    logic        i_flush;
    logic        i_jump;
    logic [31:0] i_jump_addr;
    logic        i_imem_wr_en;
    logic [31:0] i_imem_wr_addr;
    logic [31:0] i_imem_wr_data;
    logic [31:0] o_pc;
    logic [31:0] o_if_id_pc4;
    logic [31:0] o_if_id_instr;
    logic        o_halt;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        halt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    localparam logic [31:0] P0   = 32'h2001_0005;
    localparam logic [31:0] P1   = 32'h2002_0003;
    localparam logic [31:0] WA   = 32'h2003_0001;
    localparam logic [31:0] WB   = 32'h2004_0002;
    localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
    localparam logic [31:0] WC   = 32'h2005_0007;
    localparam logic [31:0] WD   = 32'h2006_0008;
    localparam logic [31:0] W255 = 32'h2007_000A;
    localparam logic [31:0] W80  = 32'h1234_5678;

    fetch_stage #(
        .IMEM_DEPTH (256),
        .PC_RESET   (32'h0000_0000)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_pc_write     (i_pc_write),
        .i_if_id_write  (i_if_id_write),
        .i_flush        (i_flush),
        .i_jump         (i_jump),
        .i_jump_addr    (i_jump_addr),
        .i_imem_wr_en   (i_imem_wr_en),
        .i_imem_wr_addr (i_imem_wr_addr),
        .i_imem_wr_data (i_imem_wr_data),
        .o_pc           (o_pc),
        .o_if_id_pc4    (o_if_id_pc4),
        .o_if_id_instr  (o_if_id_instr),
        .o_halt         (o_halt)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, queue the expected post-edge state, then compare it.
    task automatic step(input string tag, input logic rst, input logic en, input logic pw,
                        input logic iw, input logic fl, input logic jp, input logic [31:0] ja,
                        input logic [31:0] e_pc, input logic [31:0] e_pc4,
                        input logic [31:0] e_instr, input logic e_halt);
        exp_t e;
        i_reset       = rst;
        i_enable      = en;
        i_pc_write    = pw;
        i_if_id_write = iw;
        i_flush       = fl;
        i_jump        = jp;
        i_jump_addr   = ja;
        e.tag = tag; e.pc = e_pc; e.pc4 = e_pc4; e.instr = e_instr; e.halt = e_halt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check32({e.tag, ".pc"},    o_pc,          e.pc);
        check32({e.tag, ".pc4"},   o_if_id_pc4,   e.pc4);
        check32({e.tag, ".instr"}, o_if_id_instr, e.instr);
        check32({e.tag, ".halt"},  {31'd0, o_halt}, {31'd0, e.halt});
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        i_imem_wr_en   = 1'b1;
        i_imem_wr_addr = addr;
        i_imem_wr_data = data;
        @(posedge clk);
        #1;
        i_imem_wr_en   = 1'b0;
    endtask

    initial begin
        logic [31:0] prog_addr [8];
        logic [31:0] prog_data [8];
        prog_addr = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h40, 32'h44, 32'h7FC};
        prog_data = '{P0, P1, WA, WB, HLT, WC, WD, W255};

        i_reset = 1'b1; i_enable = 1'b0; i_pc_write = 1'b0; i_if_id_write = 1'b0;
        i_flush = 1'b0; i_jump = 1'b0; i_jump_addr = '0;
        i_imem_wr_en = 1'b0; i_imem_wr_addr = '0; i_imem_wr_data = '0;
        #1;

        for (int i = 0; i < 8; i++) load_word(prog_addr[i], prog_data[i]);

        step("reset",      1, 0, 0, 0, 0, 0, 32'h0,   32'h0,  32'h0,  32'h0, 0);
        step("adv0",       0, 1, 1, 1, 0, 0, 32'h0,   32'h4,  32'h4,  P0,    0);
        step("adv1",       0, 1, 1, 1, 0, 0, 32'h0,   32'h8,  32'h8,  P1,    0);
        step("stall0",     0, 1, 0, 0, 0, 0, 32'h0,   32'h8,  32'h8,  P1,    0);
        step("stall1_jf",  0, 1, 0, 0, 1, 1, 32'h80,  32'h8,  32'h8,  P1,    0);
        step("release",    0, 1, 1, 1, 0, 0, 32'h0,   32'hC,  32'hC,  WA,    0);
        step("jump_flush", 0, 1, 1, 1, 1, 1, 32'h40,  32'h40, 32'h0,  32'h0, 0);
        step("adv_40",     0, 1, 1, 1, 0, 0, 32'h0,   32'h44, 32'h44, WC,    0);

        i_imem_wr_en = 1'b1; i_imem_wr_addr = 32'h80; i_imem_wr_data = W80;
        step("dis0_wr",    0, 0, 1, 1, 1, 1, 32'h100, 32'h44, 32'h44, WC,    0);
        i_imem_wr_en = 1'b0;
        step("dis1",       0, 0, 1, 1, 0, 0, 32'h0,   32'h44, 32'h44, WC,    0);
        step("dis2",       0, 0, 1, 1, 1, 0, 32'h0,   32'h44, 32'h44, WC,    0);

        step("jump_43",    0, 1, 1, 1, 0, 1, 32'h43,  32'h40, 32'h48, WD,    0);
        step("adv_40b",    0, 1, 1, 1, 0, 0, 32'h0,   32'h44, 32'h44, WC,    0);
        step("jump_80",    0, 1, 1, 1, 1, 1, 32'h80,  32'h80, 32'h0,  32'h0, 0);
        step("adv_80",     0, 1, 1, 1, 0, 0, 32'h0,   32'h84, 32'h84, W80,   0);
        step("jump_top",   0, 1, 1, 1, 1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
        step("wrap",       0, 1, 1, 1, 0, 0, 32'h0,   32'h0,  32'h0,  W255,  0);
        step("run0",       0, 1, 1, 1, 0, 0, 32'h0,   32'h4,  32'h4,  P0,    0);
        step("run1",       0, 1, 1, 1, 0, 0, 32'h0,   32'h8,  32'h8,  P1,    0);
        step("run2",       0, 1, 1, 1, 0, 0, 32'h0,   32'hC,  32'hC,  WA,    0);
        step("run3",       0, 1, 1, 1, 0, 0, 32'h0,   32'h10, 32'h10, WB,    0);
        step("halt_flush", 0, 1, 1, 1, 1, 1, 32'h10,  32'h10, 32'h0,  32'h0, 0);
        step("halt_fetch", 0, 1, 1, 1, 0, 0, 32'h0,   32'h14, 32'h14, HLT,   1);
        step("halting_st", 0, 1, 1, 0, 0, 0, 32'h0,   32'h14, 32'h14, HLT,   1);
        step("halted",     0, 1, 1, 1, 0, 0, 32'h0,   32'h14, 32'h0,  32'h0, 1);
        step("halted_jmp", 0, 1, 1, 1, 0, 1, 32'h40,  32'h14, 32'h0,  32'h0, 1);
        step("halted_dis", 0, 0, 1, 1, 0, 0, 32'h0,   32'h14, 32'h0,  32'h0, 1);
        step("reset_halt", 1, 1, 1, 1, 0, 0, 32'h0,   32'h0,  32'h0,  32'h0, 0);
        step("post_reset", 0, 1, 1, 1, 0, 0, 32'h0,   32'h4,  32'h4,  P0,    0);

        check32("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
